forward_hazard_unit: RTL and testbench
======================================

Name: forward_hazard_unit

Overview:
- Produces the 2-bit select codes for the two ALU-operand forwarding 3:1 muxes in EX.
- Generates load-use stall and branch flush controls for the 5-stage RV32I pipeline.
- Tracks destination-register tags internally as ID→EX→MEM→WB shift registers, so it needs only decode-stage fields and EX-stage events as inputs.
- Sits between ID decode and the EX operand muxes. Also keeps saturating stall/flush event counters for debug.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  REG_AW  ID source register 1.
- id_rs2  input  REG_AW  ID source register 2.
- id_uses_rs1  input  1  instruction reads rs1.
- id_uses_rs2  input  1  instruction reads rs2.
- id_rd  input  REG_AW  ID destination register.
- id_regwrite  input  1  instruction writes rd.
- id_memread  input  1  instruction is a load.
- ex_branch_taken  input  1  EX resolved a taken branch/jump this cycle.
- forward_a  output  2  select for the operand-A mux.
- forward_b  output  2  select for the operand-B mux.
- stall  output  1  hold PC and IF/ID; bubble into EX.
- flush  output  1  squash IF/ID and ID/EX.
- stall_cnt  output  CNT_W  saturating count of stall cycles.
- flush_cnt  output  CNT_W  saturating count of flush cycles.

Behaviour:
- Select encoding is fixed:
  - 2'b00 = register-file value
  - 2'b01 = MEM/WB result
  - 2'b10 = EX/MEM ALU result
  - 2'b11 is never driven.
- Internal tag registers:
  - EX slot: rs1, rs2, use bits, rd, regwrite, memread.
  - MEM slot: rd, regwrite, memread.
  - WB slot: rd, regwrite.
- Each clock edge: WB←MEM, MEM←EX. EX←ID fields, except that EX loads a bubble (all enables 0) when stall=1, flush=1 or id_valid=0.
- forward_a, from registered EX/MEM/WB tags only:
  - 2'b10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs1 && ex_uses_rs1.
  - else 2'b01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1 && ex_uses_rs1.
  - else 2'b00.
  - MEM priority over WB is mandatory.
- forward_b: identical rule using rs2.
- x0 (rd==0) is never forwarded.
- A load in MEM matching EX is still forwarded with 2'b10. The load-use stall guarantees this case never occurs with valid data.
- stall (combinational) = ex_memread && ex_rd!=0 && id_valid && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)) && !ex_branch_taken.
  - Exactly one stall cycle per load-use pair.
  - The following cycle the load is in MEM, so no re-stall occurs.
- flush = ex_branch_taken.
  - Flush overrides stall in the same cycle; stall is forced to 0.
  - Exactly one cycle of flush per taken branch; the EX slot becomes a bubble next cycle.
- stall_cnt and flush_cnt increment by 1 on each cycle their signal is 1, and saturate at all-ones.
- Reset (synchronous, active-high):
  - All tag registers and enables cleared.
  - forward_a = forward_b = 2'b00, stall=0, flush=0, counters=0.
  - Reset asserted mid-stall or mid-flush clears state on that edge; the first cycle after reset shows no forwarding.
- Latency:
  - Forward selects reflect the instruction that was in ID one cycle earlier.
  - stall and flush are same-cycle combinational.

Decomposition:
- Shared package riscv_fwd_pkg holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_AW default.
  - Stage-tag struct {rd, regwrite, memread}.
- One sub-module: fwd_select.
  - Purely combinational priority comparator.
  - Takes one source register plus MEM/WB tags and returns a 2-bit select.
  - Instantiated twice, once for A and once for B.
- Tag pipeline and counters stay in the top level.

Test Plan:
- add x5 then add x6,x5,x7 back-to-back → second instruction in EX: forward_a=2'b10, forward_b=2'b00, stall=0.
- add x5; nop; sub x8,x1,x5 → sub in EX: forward_b=2'b01. Then add x5; add x5; sub x8,x5,x5 → forward_a=forward_b=2'b10, proving MEM priority.
- lw x9 then add x10,x9,x2 → one cycle stall=1 and stall_cnt=1; next cycle EX is a bubble; one cycle later forward_a=2'b01.
- Writes to x0 followed by an instruction reading x0 → forward_a=forward_b=2'b00 throughout.
- ex_branch_taken=1 in the same cycle as a load-use match → flush=1, stall=0, flush_cnt=1; next cycle all EX enables are 0.
- Reset asserted during a stall with CNT_W=2, after forcing 5 stalls → stall_cnt saturates at 3 before reset, reads 0 after reset, and all outputs are 0.

Source files
------------

// File: rtl/riscv_fwd_pkg.sv
// Shared select codes and stage tag type for the EX operand forwarding logic.
package riscv_fwd_pkg;

    localparam int unsigned DEF_REG_AW = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [DEF_REG_AW-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } stage_tag_t;

endpackage

// File: rtl/fwd_select.sv
// Priority comparator choosing the operand source for one EX source register.
module fwd_select
    import riscv_fwd_pkg::*;
#(
    parameter int unsigned REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              uses,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        sel_c
);

    // The younger producer in MEM wins over WB; x0 is never a forwarding source.
    always_comb begin
        sel_c = FWD_REG;
        if (uses && mem_regwrite && (mem_rd != '0) && (mem_rd == rs)) begin
            sel_c = FWD_MEM;
        end else if (uses && wb_regwrite && (wb_rd != '0) && (wb_rd == rs)) begin
            sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding selects, load-use stall and branch flush for a 5-stage RV32I pipeline,
// with an internal ID->EX->MEM->WB destination tag pipeline and debug counters.
module forward_hazard_unit
    import riscv_fwd_pkg::*;
#(
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              ex_uses_rs1;
    logic              ex_uses_rs2;
    stage_tag_t        ex_tag;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_regwrite;

    logic              load_use_c;
    logic              bubble_c;

    // A load in EX whose rd is read by the instruction in ID; a taken branch squashes both.
    always_comb begin
        load_use_c = ex_tag.memread && (ex_tag.rd != '0) && id_valid &&
                     ((id_uses_rs1 && (id_rs1 == ex_tag.rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_tag.rd)));
        flush      = ex_branch_taken;
        stall      = load_use_c && !ex_branch_taken;
        bubble_c   = stall || flush || !id_valid;
    end

    // Tag shift register: WB <- MEM <- EX <- ID (or a bubble).
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_uses_rs1  <= 1'b0;
            ex_uses_rs2  <= 1'b0;
            ex_tag       <= '0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
        end else begin
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
            mem_rd       <= ex_tag.rd;
            mem_regwrite <= ex_tag.regwrite;
            if (bubble_c) begin
                ex_rs1      <= '0;
                ex_rs2      <= '0;
                ex_uses_rs1 <= 1'b0;
                ex_uses_rs2 <= 1'b0;
                ex_tag      <= '0;
            end else begin
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_uses_rs1 <= id_uses_rs1;
                ex_uses_rs2 <= id_uses_rs2;
                ex_tag      <= '{rd: id_rd, regwrite: id_regwrite, memread: id_memread};
            end
        end
    end

    // Saturating debug event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .rs           (ex_rs1),
        .uses         (ex_uses_rs1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel_c        (forward_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .rs           (ex_rs2),
        .uses         (ex_uses_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel_c        (forward_b)
    );

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench: directed hazard scenarios plus random instruction streams
// compared against an in-order pipeline history model.
module tb_forward_hazard_unit;

    typedef struct packed {
        bit       v;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } ins_t;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        ex_branch_taken;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic        stall;
    logic        flush;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [1:0]  s_forward_a;
    logic [1:0]  s_forward_b;
    logic        s_stall;
    logic        s_flush;
    logic [1:0]  s_stall_cnt;
    logic [1:0]  s_flush_cnt;

    forward_hazard_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
        .forward_a(forward_a), .forward_b(forward_b), .stall(stall), .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    forward_hazard_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
        .forward_a(s_forward_a), .forward_b(s_forward_b), .stall(s_stall), .flush(s_flush),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB, holding whole instructions.
    ins_t pipe [3];
    ins_t cur;
    bit   cur_br;
    int   m_scnt, m_fcnt, m_scnt_sat;
    logic [1:0] exp_fa, exp_fb;
    logic exp_stall, exp_flush;

    function automatic ins_t alu(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        ins_t i = '0;
        i.v = 1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1; i.u2 = 1; i.rw = 1;
        return i;
    endfunction

    function automatic ins_t ld(input bit [4:0] rd, input bit [4:0] rs1);
        ins_t i = '0;
        i.v = 1; i.rd = rd; i.rs1 = rs1; i.u1 = 1; i.rw = 1; i.mr = 1;
        return i;
    endfunction

    // Nearest older instruction that writes a nonzero matching rd supplies the operand.
    function automatic logic [1:0] ref_fwd(input bit [4:0] r, input bit u);
        if (!u) return 2'b00;
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == r)
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        m_scnt = 0; m_fcnt = 0; m_scnt_sat = 0;
    endtask

    // Present an instruction in ID, move to the sampling point and form expectations.
    task automatic drive(input ins_t i, input bit br);
        cur = i; cur_br = br;
        id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_uses_rs1 = i.u1;
        id_uses_rs2 = i.u2; id_rd = i.rd; id_regwrite = i.rw; id_memread = i.mr;
        ex_branch_taken = br;
        @(negedge clk);
        exp_fa    = ref_fwd(pipe[0].rs1, pipe[0].u1);
        exp_fb    = ref_fwd(pipe[0].rs2, pipe[0].u2);
        exp_flush = br;
        exp_stall = !br && pipe[0].mr && pipe[0].rd != 0 && i.v &&
                    ((i.u1 && i.rs1 == pipe[0].rd) || (i.u2 && i.rs2 == pipe[0].rd));
    endtask

    // Clock edge: model history advances (or clears on reset).
    task automatic advance();
        if (reset) begin
            clear_model();
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (exp_stall || exp_flush || !cur.v) ? ins_t'('0) : cur;
            if (exp_stall && m_scnt < 65535) m_scnt++;
            if (exp_flush && m_fcnt < 65535) m_fcnt++;
            if (exp_stall && m_scnt_sat < 3) m_scnt_sat++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive('0, 1'b0);
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive('0, 1'b0);
        n_cmp++;
        if ({forward_a, forward_b, stall, flush} !== 6'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 000000", {forward_a, forward_b, stall, flush});
        end
        n_cmp++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        advance();
    endtask

    task automatic test_ex_forward();
        do_reset();
        drive(alu(5, 1, 2), 0); advance();
        drive(alu(6, 5, 7), 0); advance();
        drive('0, 0);
        n_cmp++;
        if (forward_a !== 2'b10) begin
            n_fail++; $display("FAIL ex_fwd_a: got %b expected 10", forward_a);
        end
        n_cmp++;
        if (forward_b !== 2'b00 || stall !== 1'b0) begin
            n_fail++; $display("FAIL ex_fwd_b_stall: got %b/%b expected 00/0", forward_b, stall);
        end
        advance();
    endtask

    task automatic test_wb_and_priority();
        do_reset();
        drive(alu(5, 1, 2), 0); advance();
        drive('0, 0); advance();
        drive(alu(8, 1, 5), 0); advance();
        drive('0, 0);
        n_cmp++;
        if (forward_a !== 2'b00 || forward_b !== 2'b01) begin
            n_fail++; $display("FAIL wb_fwd: got a=%b b=%b expected a=00 b=01", forward_a, forward_b);
        end
        advance();
        drive(alu(5, 1, 2), 0); advance();
        drive(alu(5, 3, 4), 0); advance();
        drive(alu(8, 5, 5), 0); advance();
        drive('0, 0);
        n_cmp++;
        if (forward_a !== 2'b10 || forward_b !== 2'b10) begin
            n_fail++; $display("FAIL mem_priority: got a=%b b=%b expected a=10 b=10", forward_a, forward_b);
        end
        advance();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(ld(9, 1), 0); advance();
        drive(alu(10, 9, 2), 0);
        n_cmp++;
        if (stall !== 1'b1 || flush !== 1'b0) begin
            n_fail++; $display("FAIL load_use_stall: got stall=%b flush=%b expected 1/0", stall, flush);
        end
        advance();
        drive(alu(10, 9, 2), 0);
        n_cmp++;
        if (stall !== 1'b0 || stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL load_use_once: got stall=%b cnt=%0d expected 0/1", stall, stall_cnt);
        end
        n_cmp++;
        if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
            n_fail++; $display("FAIL load_use_bubble: got a=%b b=%b expected 00/00", forward_a, forward_b);
        end
        advance();
        drive('0, 0);
        n_cmp++;
        if (forward_a !== 2'b01) begin
            n_fail++; $display("FAIL load_use_wb_fwd: got %b expected 01", forward_a);
        end
        advance();
    endtask

    task automatic test_x0();
        do_reset();
        drive(alu(0, 1, 2), 0); advance();
        drive(ld(0, 3), 0); advance();
        for (int c = 0; c < 3; c++) begin
            drive((c == 0) ? alu(5, 0, 0) : ins_t'('0), 0);
            n_cmp++;
            if (forward_a !== 2'b00 || forward_b !== 2'b00 || stall !== 1'b0) begin
                n_fail++; $display("FAIL x0_no_fwd: cycle %0d got a=%b b=%b stall=%b expected 00/00/0",
                                   c, forward_a, forward_b, stall);
            end
            advance();
        end
    endtask

    task automatic test_branch_flush();
        do_reset();
        drive(ld(9, 1), 0); advance();
        drive(alu(10, 9, 2), 1);
        n_cmp++;
        if (flush !== 1'b1 || stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_over_stall: got flush=%b stall=%b expected 1/0", flush, stall);
        end
        advance();
        drive(alu(11, 9, 9), 0);
        n_cmp++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL flush_cnt: got flush=%0d stall=%0d expected 1/0", flush_cnt, stall_cnt);
        end
        n_cmp++;
        if (forward_a !== 2'b00 || forward_b !== 2'b00 || stall !== 1'b0 || flush !== 1'b0) begin
            n_fail++; $display("FAIL flush_bubble: got a=%b b=%b stall=%b flush=%b expected 00/00/0/0",
                               forward_a, forward_b, stall, flush);
        end
        advance();
    endtask

    task automatic test_saturation_reset();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            drive(ld(9, 1), 0); advance();
            drive(alu(10, 9, 2), 0); advance();
            drive(alu(10, 9, 2), 0); advance();
        end
        drive(ld(9, 1), 0); advance();
        reset = 1'b1;
        drive(alu(10, 9, 2), 0);
        n_cmp++;
        if (s_stall !== 1'b1 || s_stall_cnt !== 2'd3) begin
            n_fail++; $display("FAIL sat_before_reset: got stall=%b cnt=%0d expected 1/3", s_stall, s_stall_cnt);
        end
        n_cmp++;
        if (stall_cnt !== 16'd5) begin
            n_fail++; $display("FAIL wide_cnt: got %0d expected 5", stall_cnt);
        end
        advance();
        reset = 1'b0;
        drive('0, 0);
        n_cmp++;
        if (s_stall_cnt !== 2'd0 || s_flush_cnt !== 2'd0 ||
            {s_forward_a, s_forward_b, s_stall, s_flush} !== 6'b0) begin
            n_fail++; $display("FAIL sat_after_reset: got cnt=%0d/%0d outs=%b expected 0/0/000000",
                               s_stall_cnt, s_flush_cnt, {s_forward_a, s_forward_b, s_stall, s_flush});
        end
        advance();
    endtask

    task automatic test_random();
        ins_t i;
        bit   br;
        do_reset();
        i = '0;
        for (int c = 0; c < 400; c++) begin
            if (!exp_stall || c == 0) begin
                i = '0;
                i.v   = ($urandom_range(0, 7) != 0);
                i.rs1 = 5'($urandom_range(0, 3));
                i.rs2 = 5'($urandom_range(0, 3));
                i.u1  = 1'($urandom);
                i.u2  = 1'($urandom);
                i.rd  = 5'($urandom_range(0, 3));
                i.rw  = 1'($urandom);
                i.mr  = i.rw && ($urandom_range(0, 2) == 0);
            end
            br = ($urandom_range(0, 7) == 0);
            drive(i, br);
            n_cmp++;
            if (forward_a !== exp_fa || forward_b !== exp_fb) begin
                n_fail++; $display("FAIL rand_fwd: cycle %0d got a=%b b=%b expected a=%b b=%b",
                                   c, forward_a, forward_b, exp_fa, exp_fb);
            end
            n_cmp++;
            if (stall !== exp_stall || flush !== exp_flush) begin
                n_fail++; $display("FAIL rand_ctrl: cycle %0d got stall=%b flush=%b expected %b/%b",
                                   c, stall, flush, exp_stall, exp_flush);
            end
            n_cmp++;
            if (stall_cnt !== 16'(m_scnt) || flush_cnt !== 16'(m_fcnt) || s_stall_cnt !== 2'(m_scnt_sat)) begin
                n_fail++; $display("FAIL rand_cnt: cycle %0d got %0d/%0d/%0d expected %0d/%0d/%0d",
                                   c, stall_cnt, flush_cnt, s_stall_cnt, m_scnt, m_fcnt, m_scnt_sat);
            end
            advance();
        end
    endtask

    initial begin
        reset = 1'b1;
        exp_stall = 1'b0;
        exp_flush = 1'b0;
        clear_model();
        test_reset();
        test_ex_forward();
        test_wb_and_priority();
        test_load_use();
        test_x0();
        test_branch_flush();
        test_saturation_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
